input_debouncer: RTL and testbench



---
 rtl/input_debouncer.sv | 87 ++++++++
 tb/tb_input_debouncer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Per-channel 2-FF synchronizer, stability-counter debouncer and edge/toggle generator
// for mechanical switches and buttons. Every output is a flop; i_raw reaches logic only via s1.
module input_debouncer #(
  parameter int N           = 8,
  parameter int CLK_FREQ    = 12000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_raw,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall,
  output logic [N-1:0] o_toggle
);

  localparam int STABLE_RAW    = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int STABLE_CYCLES = (STABLE_RAW < 1) ? 1 : STABLE_RAW;
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [N-1:0]            s1_q;
  logic [N-1:0]            s2_q;
  logic [N-1:0][CNT_W-1:0] cnt_q;
  logic [N-1:0][CNT_W-1:0] cnt_d;
  logic [N-1:0]            level_q;
  logic [N-1:0]            level_d;
  logic [N-1:0]            rise_q;
  logic [N-1:0]            rise_d;
  logic [N-1:0]            fall_q;
  logic [N-1:0]            fall_d;
  logic [N-1:0]            toggle_q;
  logic [N-1:0]            toggle_d;

  // Qualify phase: count while the synchronized input disagrees with level; commit on the last count.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = '0;
    fall_d   = '0;
    toggle_d = toggle_q;
    for (int n = 0; n < N; n++) begin
      if (s2_q[n] != level_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          cnt_d[n]    = CNT_ZERO;
          level_d[n]  = s2_q[n];
          rise_d[n]   = s2_q[n];
          fall_d[n]   = ~s2_q[n];
          toggle_d[n] = toggle_q[n] ^ s2_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_ONE;
        end
      end else begin
        cnt_d[n] = CNT_ZERO;
      end
    end
  end

  // State and output registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
    end else begin
      s1_q     <= i_raw;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign o_level  = level_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;
  assign o_toggle = toggle_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench: window-rule reference model, test-plan sequences, a vector table
// and randomized stimulus for input_debouncer with STABLE_CYCLES = 5.
module tb_input_debouncer;

  localparam int S = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_raw = 4'b0000;
  logic [3:0] o_level, o_rise, o_fall, o_toggle;

  int checks = 0;
  int failures = 0;

  // Reference model: a channel commits when its last S synchronized samples all differ from the level.
  logic [S:0] hist [4];
  logic [3:0] exp_level, exp_rise, exp_fall, exp_toggle;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_level;
  } vec_t;
  vec_t vecs [6];

  input_debouncer #(.N(4), .CLK_FREQ(1000), .DEBOUNCE_MS(5)) dut (
    .clk(clk), .rst(rst), .i_raw(i_raw),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_toggle(o_toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) hist[c] = '0;
    exp_level = '0; exp_rise = '0; exp_fall = '0; exp_toggle = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < 4; c++) begin
      logic all_diff;
      all_diff = 1'b1;
      for (int j = 1; j <= S; j++)
        if (hist[c][j] == exp_level[c]) all_diff = 1'b0;
      exp_rise[c] = 1'b0;
      exp_fall[c] = 1'b0;
      if (all_diff) begin
        exp_level[c] = ~exp_level[c];
        if (exp_level[c]) begin
          exp_rise[c]   = 1'b1;
          exp_toggle[c] = ~exp_toggle[c];
        end else begin
          exp_fall[c] = 1'b1;
        end
      end
      for (int j = S; j >= 1; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = i_raw[c];
    end
  endtask

  // One clock: model advances at the active edge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", {o_level, o_rise, o_fall, o_toggle}, {exp_level, exp_rise, exp_fall, exp_toggle});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    string ev;
    logic [3:0] r;

    vecs[0] = '{raw: 4'b0101, hold: 8, exp_level: 4'b0101};
    vecs[1] = '{raw: 4'b0011, hold: 3, exp_level: 4'b0101};
    vecs[2] = '{raw: 4'b0011, hold: 8, exp_level: 4'b0011};
    vecs[3] = '{raw: 4'b1100, hold: 6, exp_level: 4'b0011};
    vecs[4] = '{raw: 4'b1100, hold: 1, exp_level: 4'b1100};
    vecs[5] = '{raw: 4'b0000, hold: 7, exp_level: 4'b0000};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", {o_level, o_rise, o_fall, o_toggle}, 16'h0000);
    rst = 1'b0;
    ticks(3);

    // Clean press on channel 0
    i_raw = 4'b0001;
    ticks(6);
    chk("press_before", {12'h000, o_level}, 16'h0000);
    tick();
    chk("press_commit", {4'h0, o_level, o_rise, o_toggle}, 16'h0111);
    tick();
    chk("press_pulse_end", {12'h000, o_rise}, 16'h0000);
    i_raw = 4'b0000;
    ticks(10);

    // Bounce on channel 1
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      i_raw[1] = (k < 3 || (k >= 4 && k < 8)) ? 1'b1 : 1'b0;
      tick();
      cnt += int'(o_rise[1]) + int'(o_fall[1]);
    end
    i_raw[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += int'(o_rise[1]);
    end
    chk("bounce_no_pulse", 16'(cnt), 16'd0);
    tick();
    chk("bounce_rise", {15'h0, o_rise[1]}, 16'h0001);
    tick();
    chk("bounce_single", {15'h0, o_rise[1]}, 16'h0000);

    // Press / release / press on channel 2
    ev = "";
    cnt = -1;
    i_raw[2] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 20) i_raw[2] = 1'b0;
      if (k == 40) i_raw[2] = 1'b1;
      tick();
      if (o_rise[2]) ev = {ev, o_toggle[2] ? "R1" : "R0"};
      if (o_fall[2]) begin
        ev = {ev, o_toggle[2] ? "F1" : "F0"};
        cnt = k - 20 + 1;
      end
    end
    checks++;
    if (ev != "R1F1R0") begin
      failures++;
      $display("FAIL toggle_seq: got %s expected R1F1R0", ev);
    end
    chk("fall_timing", 16'(cnt), 16'd7);

    // Simultaneous channels
    i_raw = 4'b0000;
    ticks(10);
    i_raw = 4'b1111;
    ticks(6);
    chk("simul_before", {8'h00, o_level, o_rise}, 16'h0000);
    tick();
    chk("simul_commit", {8'h00, o_level, o_rise}, 16'h00FF);
    tick();
    chk("simul_pulse_end", {12'h000, o_rise}, 16'h0000);

    // Reset in the middle of qualification
    i_raw = 4'b0000;
    ticks(10);
    i_raw = 4'b1000;
    ticks(3);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("async_reset", {o_level, o_rise, o_fall, o_toggle}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("reset_hold", {o_level, o_rise, o_fall, o_toggle}, 16'h0000);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += int'(o_rise[3]);
    end
    chk("rst_no_early_rise", 16'(cnt), 16'd0);
    tick();
    chk("rst_rise", {12'h000, o_rise}, 16'h0008);

    // Sub-threshold pulse on channel 0
    i_raw = 4'b0000;
    ticks(10);
    cnt = 0;
    i_raw[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 4) i_raw[0] = 1'b0;
      tick();
      cnt += int'(o_level[0]) + int'(|o_rise) + int'(|o_fall);
    end
    chk("subthreshold", 16'(cnt), 16'd0);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      i_raw = vecs[v].raw;
      ticks(vecs[v].hold);
      chk($sformatf("vec%0d_level", v), {12'h000, o_level}, {12'h000, vecs[v].exp_level});
    end

    // Randomized: each channel flips with low probability so some runs qualify and some bounce
    for (int k = 0; k < 600; k++) begin
      r = i_raw;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
      i_raw = r;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
